dcache_to_mem_adapter: RTL

//  Reverse of the MEM->DCACHE converter: a responder on a CVA6 dcache request port that emits
//  MEM-protocol master transactions (req/gnt/valid). Lets cache-port clients (PTW, LSU ports)

---
 rtl/dcache_to_mem_adapter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/dcache_to_mem_adapter.sv
// Responder on a dcache request port that replays each request as one MEM-bus master
// transaction (req/gnt/valid); one transaction outstanding at a time.
module dcache_to_mem_adapter #(
  parameter int unsigned INDEX_W = 12,
  parameter int unsigned TAG_W   = 44,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned ID_W    = 4,
  parameter int unsigned ADDR_W  = 64
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic [INDEX_W-1:0]  address_index_i,
  input  logic [TAG_W-1:0]    address_tag_i,
  input  logic                data_req_i,
  input  logic                data_we_i,
  input  logic [DATA_W/8-1:0] data_be_i,
  input  logic [DATA_W-1:0]   data_wdata_i,
  input  logic [ID_W-1:0]     data_id_i,
  input  logic                tag_valid_i,
  input  logic                kill_req_i,
  output logic                data_gnt_o,
  output logic                data_rvalid_o,
  output logic [ID_W-1:0]     data_rid_o,
  output logic [DATA_W-1:0]   data_rdata_o,
  output logic                data_rerr_o,
  output logic                m_mem_req,
  input  logic                m_mem_gnt,
  output logic [ADDR_W-1:0]   m_mem_addr,
  output logic                m_mem_we,
  output logic [DATA_W/8-1:0] m_mem_be,
  output logic [DATA_W-1:0]   m_mem_wdata,
  input  logic                m_mem_valid,
  input  logic [DATA_W-1:0]   m_mem_rdata,
  input  logic                m_mem_error
);

  localparam int unsigned BeW = DATA_W / 8;

  typedef enum logic [2:0] {StIdle, StWaitTag, StIssue, StWaitRsp, StDrop} state_e;

  state_e              state_q, state_d;
  logic [INDEX_W-1:0]  idx_q, idx_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [BeW-1:0]      be_q, be_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                drop_q, drop_d;
  logic                rvalid_q, rvalid_d;
  logic [ID_W-1:0]     rid_q, rid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rerr_q, rerr_d;
  logic                drop_now;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    tag_d      = tag_q;
    id_d       = id_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    drop_d     = drop_q;
    rvalid_d   = 1'b0;
    rid_d      = rid_q;
    rdata_d    = rdata_q;
    rerr_d     = rerr_q;
    data_gnt_o = 1'b0;
    m_mem_req  = 1'b0;
    drop_now   = drop_q | flush_i;

    unique case (state_q)
      StIdle: begin
        data_gnt_o = data_req_i & ~rst_i;
        if (data_req_i) begin
          idx_d   = address_index_i;
          id_d    = data_id_i;
          be_d    = data_be_i;
          wdata_d = data_wdata_i;
          we_d    = data_we_i;
          drop_d  = 1'b0;
          if (data_we_i) begin
            tag_d   = address_tag_i;
            state_d = StIssue;
          end else begin
            state_d = StWaitTag;
          end
        end
      end
      StWaitTag: begin
        if (kill_req_i || flush_i) begin
          // Killed loads still get an ack so the client can retire the id.
          state_d  = StIdle;
          rvalid_d = 1'b1;
          rid_d    = id_q;
          rdata_d  = '0;
          rerr_d   = 1'b0;
        end else if (tag_valid_i) begin
          tag_d   = address_tag_i;
          state_d = StIssue;
        end
      end
      StIssue: begin
        m_mem_req = 1'b1;
        drop_d    = drop_now;
        if (m_mem_gnt) begin
          if (m_mem_valid) begin
            state_d = StIdle;
            if (!we_q && !drop_now) begin
              rvalid_d = 1'b1;
              rid_d    = id_q;
              rdata_d  = m_mem_rdata;
              rerr_d   = m_mem_error;
            end
          end else begin
            state_d = drop_now ? StDrop : StWaitRsp;
          end
        end
      end
      StWaitRsp: begin
        if (m_mem_valid) begin
          state_d = StIdle;
          if (!we_q && !flush_i) begin
            rvalid_d = 1'b1;
            rid_d    = id_q;
            rdata_d  = m_mem_rdata;
            rerr_d   = m_mem_error;
          end
        end else if (flush_i) begin
          state_d = StDrop;
        end
      end
      StDrop: begin
        if (m_mem_valid) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      tag_q    <= '0;
      id_q     <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      drop_q   <= 1'b0;
      rvalid_q <= 1'b0;
      rid_q    <= '0;
      rdata_q  <= '0;
      rerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      tag_q    <= tag_d;
      id_q     <= id_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      drop_q   <= drop_d;
      rvalid_q <= rvalid_d;
      rid_q    <= rid_d;
      rdata_q  <= rdata_d;
      rerr_q   <= rerr_d;
    end
  end

  assign data_rvalid_o = rvalid_q;
  assign data_rid_o    = rid_q;
  assign data_rdata_o  = rdata_q;
  assign data_rerr_o   = rerr_q;

  // MEM side is quiet outside an active request.
  assign m_mem_addr  = m_mem_req ? ADDR_W'({tag_q, idx_q}) : '0;
  assign m_mem_we    = m_mem_req & we_q;
  assign m_mem_be    = m_mem_req ? be_q : '0;
  assign m_mem_wdata = m_mem_req ? wdata_q : '0;

endmodule
